// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the memory port arbiter slice.
//   WORD_W / ADDR_W : memory data and address widths
//   arb_state_t     : arbiter FSM states
//   owner_t         : which requester owns the current access
package proc_pkg;

    localparam int WORD_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory pins around the arbiter.
//   f_*   : instruction-fetch requester (req/addr in, gnt/valid/rdata out)
//   d_*   : load/store requester (req/we/addr/wdata in, gnt/valid/rdata out)
//   mem_* : single shared memory (enable/write/addr/wdata out, rdata in)
// Modports: slave = arbiter side, master = requester/memory side.
interface mem_port_arbiter_if;
    import proc_pkg::*;

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_valid;
    logic [WORD_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [WORD_W-1:0] d_rdata;

    logic              mem_enable;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_gnt, f_valid, f_rdata, d_gnt, d_valid, d_rdata,
               mem_enable, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_gnt, f_valid, f_rdata, d_gnt, d_valid, d_rdata,
               mem_enable, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Winner select with starvation protection for the fetch port.
//   clk, rst  : clock, async active-high reset
//   arb_en    : arbiter is in a state that may start a new access
//   f_req     : fetch request pending
//   d_req     : data request pending
//   grant_f   : fetch wins this edge
//   grant_d   : data wins this edge
// Data has priority until STARVE_MAX consecutive data grants were given
// while a fetch waited; then the fetch is forced through.
module arb_starve_pick #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic f_req,
    input  logic d_req,
    output logic grant_f,
    output logic grant_d
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    always_comb begin
        grant_f = 1'b0;
        grant_d = 1'b0;
        if (arb_en) begin
            if (d_req && !(f_req && starve_cnt == CNT_MAX)) begin
                grant_d = 1'b1;
            end else if (f_req) begin
                grant_f = 1'b1;
            end
        end
    end

    // Counts only data grants that overtook a waiting fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!f_req || grant_f) begin
            starve_cnt <= '0;
        end else if (grant_d && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory between the fetch (F) and data (D) ports.
//   clk, rst : clock, async active-high reset
//   bus      : mem_port_arbiter_if.slave (F port, D port, memory pins)
//   busy     : FSM not in IDLE
// Optional (MEM_PORT_ARBITER_PERF_EN):
//   perf_clr : synchronous clear of the grant counters
//   f_cnt    : saturating count of F grants
//   d_cnt    : saturating count of D grants
// Parameters: MEM_LAT (1..7) read latency, STARVE_MAX (1..15).
module mem_port_arbiter
    import proc_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    input  logic                perf_clr,
    output logic [7:0]          f_cnt,
    output logic [7:0]          d_cnt
`endif
);

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    arb_state_t        state;
    owner_t            owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] f_rdata_q;
    logic [WORD_W-1:0] d_rdata_q;
    logic [2:0]        lat_cnt;

    logic arb_en;
    logic grant_f;
    logic grant_d;

    assign arb_en = (state == IDLE) || (state == RESP);

    arb_starve_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk     (clk),
        .rst     (rst),
        .arb_en  (arb_en),
        .f_req   (bus.f_req),
        .d_req   (bus.d_req),
        .grant_f (grant_f),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_F;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_cnt   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                // RESP re-arbitrates so back-to-back accesses skip IDLE.
                IDLE, RESP: begin
                    if (grant_d) begin
                        state   <= ACCESS;
                        owner   <= OWN_D;
                        we_q    <= bus.d_we;
                        addr_q  <= bus.d_addr;
                        wdata_q <= bus.d_wdata;
                    end else if (grant_f) begin
                        state  <= ACCESS;
                        owner  <= OWN_F;
                        we_q   <= 1'b0;
                        addr_q <= bus.f_addr;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state <= RESP;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_LOAD;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (owner == OWN_D) begin
                            d_rdata_q <= bus.mem_rdata;
                        end else begin
                            f_rdata_q <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.f_gnt      = (state == ACCESS) && (owner == OWN_F);
    assign bus.d_gnt      = (state == ACCESS) && (owner == OWN_D);
    assign bus.f_valid    = (state == RESP) && (owner == OWN_F);
    assign bus.d_valid    = (state == RESP) && (owner == OWN_D);
    assign bus.f_rdata    = f_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.mem_enable = (state == ACCESS);
    assign bus.mem_write  = (state == ACCESS) && we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign busy           = (state != IDLE);

`ifdef MEM_PORT_ARBITER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_cnt <= '0;
            d_cnt <= '0;
        end else if (perf_clr) begin
            f_cnt <= '0;
            d_cnt <= '0;
        end else if (state == ACCESS) begin
            if (owner == OWN_F && f_cnt != '1) begin
                f_cnt <= f_cnt + 8'd1;
            end
            if (owner == OWN_D && d_cnt != '1) begin
                d_cnt <= d_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (MEM_LAT=1 and 4),
// a latency-accurate memory model per instance, expectation queues filled
// by the stimulus and drained by negedge monitors.
module tb_mem_port_arbiter;
    import proc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nerr = 0;
    int nchk = 0;

    mem_port_arbiter_if b1();
    mem_port_arbiter_if b2();
    logic busy1, busy2;

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic       perf_clr = 1'b0;
    logic [7:0] f_cnt1, d_cnt1, f_cnt2, d_cnt2;
`endif

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (b1),
        .busy (busy1)
`ifdef MEM_PORT_ARBITER_PERF_EN
        , .perf_clr(perf_clr), .f_cnt(f_cnt1), .d_cnt(d_cnt1)
`endif
    );

    mem_port_arbiter #(.MEM_LAT(4), .STARVE_MAX(3)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .bus  (b2),
        .busy (busy2)
`ifdef MEM_PORT_ARBITER_PERF_EN
        , .perf_clr(perf_clr), .f_cnt(f_cnt2), .d_cnt(d_cnt2)
`endif
    );

    // Memory models: read data appears exactly MEM_LAT cycles after the
    // enable cycle, 8'hEE otherwise.
    logic [7:0] mem1 [256];
    logic [7:0] rd1;
    always @(posedge clk) begin
        if (rst) begin
            mem1[8'h10] <= 8'hA5;
            mem1[8'h20] <= 8'h11;
            mem1[8'h21] <= 8'h22;
            mem1[8'h30] <= 8'h33;
            mem1[8'h40] <= 8'hC0;
            mem1[8'h41] <= 8'hC1;
            mem1[8'h42] <= 8'hC2;
            mem1[8'h43] <= 8'hC3;
        end else if (b1.mem_enable && b1.mem_write) begin
            mem1[b1.mem_addr] <= b1.mem_wdata;
        end
        rd1 <= (b1.mem_enable && !b1.mem_write) ? mem1[b1.mem_addr] : 8'hEE;
    end
    assign b1.mem_rdata = rd1;

    logic [7:0] mem2 [256];
    logic [7:0] p2 [4];
    always @(posedge clk) begin
        if (rst) begin
            mem2[8'h50] <= 8'hD0;
            mem2[8'h51] <= 8'hD1;
            mem2[8'h52] <= 8'hD2;
        end
        p2[0] <= (b2.mem_enable && !b2.mem_write) ? mem2[b2.mem_addr] : 8'hEE;
        p2[1] <= p2[0];
        p2[2] <= p2[1];
        p2[3] <= p2[2];
    end
    assign b2.mem_rdata = p2[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    function automatic logic [16:0] acc(input logic w, input logic [7:0] a, input logic [7:0] d);
        return {w, a, w ? d : 8'h00};
    endfunction

    // Scoreboard for dut1
    logic [16:0] exp_mem[$];
    logic        exp_gnt[$];   // 1 = D, 0 = F
    logic [15:0] exp_f[$];     // {latency gnt->valid, rdata}
    logic [15:0] exp_d[$];
    int unsigned fg_cyc = 0;
    int unsigned dg_cyc = 0;

    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("enable_vs_gnt", 32'(b1.mem_enable), 32'(b1.f_gnt | b1.d_gnt));
                if (b1.mem_enable) begin
                    if (exp_mem.size() == 0) fail("mem_access_unexpected");
                    else chk("mem_access", 32'({b1.mem_write, b1.mem_addr,
                             b1.mem_write ? b1.mem_wdata : 8'h00}), 32'(exp_mem.pop_front()));
                end
                if (b1.f_gnt && b1.d_gnt) begin
                    fail("gnt_both");
                end else if (b1.f_gnt || b1.d_gnt) begin
                    if (b1.f_gnt) fg_cyc = cyc;
                    else dg_cyc = cyc;
                    if (exp_gnt.size() == 0) fail("gnt_unexpected");
                    else chk("gnt_owner", 32'(b1.d_gnt), 32'(exp_gnt.pop_front()));
                end
                if (b1.f_valid && b1.d_valid) fail("valid_both");
                if (b1.f_valid) begin
                    if (exp_f.size() == 0) fail("f_valid_unexpected");
                    else begin
                        e = exp_f.pop_front();
                        chk("f_rdata", 32'(b1.f_rdata), 32'(e[7:0]));
                        chk("f_latency", cyc - fg_cyc, 32'(e[15:8]));
                    end
                end
                if (b1.d_valid) begin
                    if (exp_d.size() == 0) fail("d_valid_unexpected");
                    else begin
                        e = exp_d.pop_front();
                        chk("d_rdata", 32'(b1.d_rdata), 32'(e[7:0]));
                        chk("d_latency", cyc - dg_cyc, 32'(e[15:8]));
                    end
                end
            end
        end
    end

    // Scoreboard for dut2
    logic [7:0]  exp_f2[$];
    int unsigned vc2[$];
    int unsigned me2 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (b2.mem_enable) me2++;
                if (b2.f_valid) begin
                    if (exp_f2.size() == 0) fail("f2_valid_unexpected");
                    else chk("f2_rdata", 32'(b2.f_rdata), 32'(exp_f2.pop_front()));
                    vc2.push_back(cyc);
                end
            end
        end
    end

    task automatic f_access(input logic [7:0] a, input logic last, output int unsigned n);
        b1.f_addr = a;
        b1.f_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b1.f_gnt && n < 50);
        if (!b1.f_gnt) fail("f_gnt_timeout");
        if (last) b1.f_req = 1'b0;
    endtask

    task automatic d_access(input logic w, input logic [7:0] a, input logic [7:0] wd,
                            input logic last, output int unsigned n);
        b1.d_we    = w;
        b1.d_addr  = a;
        b1.d_wdata = wd;
        b1.d_req   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b1.d_gnt && n < 50);
        if (!b1.d_gnt) fail("d_gnt_timeout");
        if (last) b1.d_req = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_mem.size() != 0 || exp_gnt.size() != 0 || exp_f.size() != 0 ||
                exp_d.size() != 0 || busy1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) fail("drain_timeout");
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nf, nd, n;
        rst = 1'b1;
        b1.f_req = 1'b0; b1.f_addr = '0;
        b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
        b2.f_req = 1'b0; b2.f_addr = '0;
        b2.d_req = 1'b0; b2.d_we = 1'b0; b2.d_addr = '0; b2.d_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_mem_enable", 32'(b1.mem_enable), 32'd0);
        chk("rst_f_rdata", 32'(b1.f_rdata), 32'd0);
        chk("rst_d_rdata", 32'(b1.d_rdata), 32'd0);

        // Fetch only, 0x10 -> 0xA5
        exp_mem.push_back(acc(1'b0, 8'h10, 8'h00));
        exp_gnt.push_back(1'b0);
        exp_f.push_back({8'd2, 8'hA5});
        f_access(8'h10, 1'b1, nf);
        chk("f_gnt_cycle", nf, 32'd1);
        drain();

        // Store 0x3C to 0xF8; d_rdata keeps its reset value
        exp_mem.push_back(acc(1'b1, 8'hF8, 8'h3C));
        exp_gnt.push_back(1'b1);
        exp_d.push_back({8'd1, 8'h00});
        d_access(1'b1, 8'hF8, 8'h3C, 1'b1, nd);
        chk("d_gnt_cycle", nd, 32'd1);
        drain();

        // Load back the stored word
        exp_mem.push_back(acc(1'b0, 8'hF8, 8'h00));
        exp_gnt.push_back(1'b1);
        exp_d.push_back({8'd2, 8'h3C});
        d_access(1'b0, 8'hF8, 8'h00, 1'b1, nd);
        drain();

        // Simultaneous requests: D first, F straight from RESP
        exp_mem.push_back(acc(1'b0, 8'h21, 8'h00));
        exp_mem.push_back(acc(1'b0, 8'h20, 8'h00));
        exp_gnt.push_back(1'b1);
        exp_gnt.push_back(1'b0);
        exp_d.push_back({8'd2, 8'h22});
        exp_f.push_back({8'd2, 8'h11});
        fork
            f_access(8'h20, 1'b1, nf);
            d_access(1'b0, 8'h21, 8'h00, 1'b1, nd);
        join
        drain();
        chk("resp_to_access_gap", fg_cyc - dg_cyc, 32'd3);

        // Starvation: D held, F pending -> D,D,D,F,D
        exp_mem.push_back(acc(1'b0, 8'h40, 8'h00));
        exp_mem.push_back(acc(1'b0, 8'h41, 8'h00));
        exp_mem.push_back(acc(1'b0, 8'h42, 8'h00));
        exp_mem.push_back(acc(1'b0, 8'h30, 8'h00));
        exp_mem.push_back(acc(1'b0, 8'h43, 8'h00));
        exp_gnt.push_back(1'b1); exp_gnt.push_back(1'b1); exp_gnt.push_back(1'b1);
        exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b1);
        exp_d.push_back({8'd2, 8'hC0}); exp_d.push_back({8'd2, 8'hC1});
        exp_d.push_back({8'd2, 8'hC2}); exp_d.push_back({8'd2, 8'hC3});
        exp_f.push_back({8'd2, 8'h33});
        fork
            begin
                f_access(8'h30, 1'b1, nf);
                chk("starve_cnt_clr", 32'(dut1.u_pick.starve_cnt), 32'd0);
            end
            begin
                d_access(1'b0, 8'h40, 8'h00, 1'b0, nd);
                d_access(1'b0, 8'h41, 8'h00, 1'b0, nd);
                d_access(1'b0, 8'h42, 8'h00, 1'b0, nd);
                chk("starve_cnt_sat", 32'(dut1.u_pick.starve_cnt), 32'd3);
                d_access(1'b0, 8'h43, 8'h00, 1'b1, nd);
            end
        join
        drain();

        // Reset during WAIT of a fetch: access dropped, no valid
        exp_mem.push_back(acc(1'b0, 8'h10, 8'h00));
        exp_gnt.push_back(1'b0);
        f_access(8'h10, 1'b1, nf);
        @(negedge clk);
        chk("in_wait_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy1), 32'd0);
        chk("rst_mid_f_rdata", 32'(b1.f_rdata), 32'd0);
        chk("rst_mid_d_rdata", 32'(b1.d_rdata), 32'd0);
        chk("rst_mid_outs", 32'({b1.f_gnt, b1.d_gnt, b1.f_valid, b1.d_valid,
                                 b1.mem_enable, b1.mem_write}), 32'd0);
        chk("rst_mid_mem_addr", 32'(b1.mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_valid_after_rst", 32'({b1.f_valid, b1.d_valid, busy1}), 32'd0);
        end

        // MEM_LAT=4 back-to-back fetches on dut2
        me2 = 0;
        vc2.delete();
        exp_f2.push_back(8'hD0); exp_f2.push_back(8'hD1); exp_f2.push_back(8'hD2);
        b2.f_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b2.f_addr = 8'h50 + 8'(i);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!b2.f_gnt && n < 50);
            if (!b2.f_gnt) fail("f2_gnt_timeout");
        end
        b2.f_req = 1'b0;
        n = 0;
        while (vc2.size() < 3 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (vc2.size() < 3) fail("f2_valid_timeout");
        else begin
            chk("f2_spacing_0", vc2[1] - vc2[0], 32'd6);
            chk("f2_spacing_1", vc2[2] - vc2[1], 32'd6);
        end
        repeat (3) @(negedge clk);
        chk("f2_enable_count", me2, 32'd3);

        chk("left_mem", exp_mem.size(), 32'd0);
        chk("left_gnt", exp_gnt.size(), 32'd0);
        chk("left_f", exp_f.size(), 32'd0);
        chk("left_d", exp_d.size(), 32'd0);
        chk("left_f2", exp_f2.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
